text_buffer_writer: RTL and testbench

Character-stream writer that fills the 256-entry text buffer scanned by the VGA text pixel renderer. It accepts one byte per cycle over a valid/ready handshake and interprets a small set of control codes. It maintains a write cursor and performs a sequential clear sweep. Its `text` output connects directly to the renderer's text array input; the renderer is the reader of that buffer and this block is the writer.

---
 rtl/text_buffer_writer.sv | 122 ++++++++++++
 tb/tb_text_buffer_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_writer.sv
// Byte-stream writer for the VGA text buffer: printable bytes, BS/CR/FF control codes, clear sweep.
// Define TEXT_SCROLL_EN so that writing past the last cell scrolls the buffer left instead of wrapping.
module text_buffer_writer #(
  parameter int unsigned DEPTH = 256,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       clear,
  output logic [7:0] text [DEPTH-1:0],
  output logic [7:0] cursor,
  output logic       busy
);

  localparam int unsigned   AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [7:0]    CH_BS = 8'h08;
  localparam logic [7:0]    CH_FF = 8'h0C;
  localparam logic [7:0]    CH_CR = 8'h0D;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          busy_q, busy_d;
  logic [7:0]    text_q [DEPTH-1:0];

  logic xfer, is_print, is_bs;
`ifdef TEXT_SCROLL_EN
  logic at_last;
  assign at_last = (cursor_q == LAST);
`endif

  assign char_ready = (state_q == ST_IDLE) && !clear;
  assign xfer       = char_valid && char_ready;
  assign is_print   = (char_in >= 8'h20) && (char_in <= 8'h7E);
  assign is_bs      = (char_in == CH_BS);

  // Next-state and cursor/sweep bookkeeping
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    sweep_d  = sweep_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clear || (xfer && char_in == CH_FF)) begin
          state_d  = ST_CLEAR;
          cursor_d = '0;
          sweep_d  = '0;
          busy_d   = 1'b1;
        end else if (xfer) begin
          if (is_print) begin
`ifdef TEXT_SCROLL_EN
            if (!at_last) cursor_d = cursor_q + AW'(1);
`else
            cursor_d = cursor_q + AW'(1);
`endif
          end else if (is_bs) begin
            if (cursor_q != '0) cursor_d = cursor_q - AW'(1);
          end else if (char_in == CH_CR) begin
            cursor_d = '0;
          end
        end
      end
      ST_CLEAR: begin
        if (sweep_q == LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          sweep_d = sweep_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cursor_q <= '0;
      sweep_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      sweep_q  <= sweep_d;
      busy_q   <= busy_d;
    end
  end

  // Character storage: reset blanks everything at once, the sweep blanks one cell per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) text_q[i] <= BLANK;
    end else if (state_q == ST_CLEAR) begin
      text_q[sweep_q] <= BLANK;
    end else if (xfer && is_print) begin
`ifdef TEXT_SCROLL_EN
      if (at_last) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) text_q[i] <= text_q[i+1];
        text_q[DEPTH-1] <= char_in;
      end else begin
        text_q[cursor_q] <= char_in;
      end
`else
      text_q[cursor_q] <= char_in;
`endif
    end else if (xfer && is_bs && cursor_q != '0) begin
      text_q[AW'(cursor_q - AW'(1))] <= BLANK;
    end
  end

  assign text   = text_q;
  assign cursor = 8'(cursor_q);
  assign busy   = busy_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer: driver pushes model predictions, monitor checks each transfer.
module tb_text_buffer_writer;

  localparam int         DEPTH = 256;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       clear = 1'b0;
  logic [7:0] text [DEPTH-1:0];
  logic [7:0] cursor;
  logic       busy;

  text_buffer_writer #(.DEPTH(DEPTH), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .clear(clear), .text(text), .cursor(cursor), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic                 full;
    logic [7:0]           cur;
    logic                 bsy;
    logic [DEPTH*8-1:0]   img;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mem [DEPTH];
  int         cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DEPTH*8-1:0] dut_img();
    logic [DEPTH*8-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*8 +: 8] = text[i];
    return f;
  endfunction

  function automatic logic [DEPTH*8-1:0] model_img();
    logic [DEPTH*8-1:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*8 +: 8] = mem[i];
    return f;
  endfunction

  task automatic chk_img(input string nm, input logic [DEPTH*8-1:0] act, input logic [DEPTH*8-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < DEPTH; i++) begin
        if (act[i*8 +: 8] !== exp[i*8 +: 8]) begin
          $display("FAIL %s: cell %0d got %0h expected %0h (t=%0t)", nm, i, act[i*8 +: 8], exp[i*8 +: 8], $time);
          break;
        end
      end
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = BLANK;
    cur = 0;
  endfunction

  // Reference behaviour of one accepted byte, straight from the character rules
  function automatic void model_apply(input logic [7:0] b);
    exp_t e;
    e.full = 1'b1;
    e.bsy  = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) begin
`ifdef TEXT_SCROLL_EN
      if (cur == DEPTH - 1) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] = mem[i+1];
        mem[DEPTH-1] = b;
      end else begin
        mem[cur] = b;
        cur++;
      end
`else
      mem[cur] = b;
      cur = (cur + 1) % DEPTH;
`endif
    end else if (b == 8'h08) begin
      if (cur > 0) begin
        cur--;
        mem[cur] = BLANK;
      end
    end else if (b == 8'h0D) begin
      cur = 0;
    end else if (b == 8'h0C) begin
      model_reset();
      e.full = 1'b0;
      e.bsy  = 1'b1;
    end
    e.cur = 8'(cur);
    e.img = model_img();
    expq.push_back(e);
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    char_in    = b;
    char_valid = 1'b1;
    clear      = 1'b0;
    model_apply(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      char_valid = 1'b0;
      clear      = 1'b0;
    end
  endtask

  // Monitor: every accepted byte pops one prediction
  logic xfer_s;
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      xfer_s = rst_n && char_valid && char_ready;
      #1;
      if (xfer_s) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got byte %0h expected no transfer (t=%0t)", char_in, $time);
        end else begin
          mon_e = expq.pop_front();
          chk("sb_cursor", 32'(cursor), 32'(mon_e.cur));
          chk("sb_busy", 32'(busy), 32'(mon_e.bsy));
          if (mon_e.full) chk_img("sb_buffer", dut_img(), mon_e.img);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic clear_with_valid();
    int cnt;
    @(negedge clk);
    clear      = 1'b1;
    char_valid = 1'b1;
    char_in    = 8'h5A;
    #1;
    chk("ready_on_clear", 32'(char_ready), 32'd0);
    model_reset();
    cnt = 0;
    for (int i = 0; i < DEPTH + 50; i++) begin
      @(negedge clk);
      clear      = 1'b0;
      char_valid = 1'b0;
      if (i == 10) chk("cursor_in_sweep", 32'(cursor), 32'd0);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    chk("busy_cycles", 32'(cnt), 32'(DEPTH));
    chk("cursor_after_clear", 32'(cursor), 32'd0);
    chk("ready_after_clear", 32'(char_ready), 32'd1);
    chk_img("buffer_after_clear", dut_img(), model_img());
  endtask

  logic [7:0] rb;
  int         r;

  initial begin
    model_reset();
    #12;
    chk("reset_cursor", 32'(cursor), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk_img("reset_buffer", dut_img(), model_img());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_ready", 32'(char_ready), 32'd1);

    send(8'h48); send(8'h49); idle(1);
    chk("hi_text0", 32'(text[0]), 32'h48);
    chk("hi_text1", 32'(text[1]), 32'h49);
    chk("hi_cursor", 32'(cursor), 32'd2);

    send(8'h61); send(8'h62); send(8'h63); send(8'h08); idle(1);
    chk("bs_cursor", 32'(cursor), 32'd4);
    chk("bs_cell", 32'(text[4]), 32'h20);
    repeat (5) send(8'h08);
    idle(1);
    chk("bs_saturate", 32'(cursor), 32'd0);

    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    send(8'h0D); send(8'h07); idle(1);
    chk("cr_cursor", 32'(cursor), 32'd0);

    for (int i = 0; i < 10; i++) send(8'h4B);
    idle(1);
    clear_with_valid();

    for (int i = 0; i < DEPTH; i++) send(8'h41);
    send(8'h42); idle(1);
`ifdef TEXT_SCROLL_EN
    chk("scroll_254", 32'(text[254]), 32'h41);
    chk("scroll_255", 32'(text[255]), 32'h42);
    chk("scroll_cursor", 32'(cursor), 32'd255);
`else
    chk("wrap_text0", 32'(text[0]), 32'h42);
    chk("wrap_text1", 32'(text[1]), 32'h41);
    chk("wrap_cursor", 32'(cursor), 32'd1);
`endif

    // Asynchronous reset in the middle of a sweep over a full buffer
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_cursor", 32'(cursor), 32'd0);
    chk_img("midreset_buffer", dut_img(), model_img());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midreset_ready", 32'(char_ready), 32'd1);

    // Random mix of printable bytes and control codes
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) rb = 8'($urandom_range(32, 126));
      else if (r < 78) rb = 8'h08;
      else if (r < 83) rb = 8'h0D;
      else if (r < 85) rb = 8'h0C;
      else begin
        rb = 8'h00;
        for (int k = 0; k < 64; k++) begin
          rb = 8'($urandom_range(0, 255));
          if (!(rb >= 8'h20 && rb <= 8'h7E) && rb != 8'h08 && rb != 8'h0C && rb != 8'h0D) break;
          rb = 8'h7F;
        end
      end
      send(rb);
      if (rb == 8'h0C) idle(DEPTH + 1);
      else if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Long printable run to cross the last cell with random content
    for (int n = 0; n < 300; n++) send(8'($urandom_range(32, 126)));

    idle(3);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
